// File: rtl/cabinet_input_conditioner.sv
// rtl/cabinet_input_conditioner.sv - registered debounce, coin shaping and per-game mapping for mylstar inputs
// Optional feature macro: INPUT_VBL_SYNC_EN (outputs reload only once per frame, on the cycle
// after a synchronised vblank rising edge). Undefined: vblank ignored, outputs update every cycle.
// Ports:
//   clk_sys    in   1  system clock
//   reset      in   1  synchronous active-high reset
//   mod        in   8  game id: 0 qbert, 1 qub, 2 mplanets, 3 krull, 4 curvebal, 5 tylz
//   joystick   in  16  raw joystick_0 bits (clk_sys domain)
//   test_sw    in   1  OSD test-mode switch, 1 = on
//   vblank     in   1  asynchronous VBlank
//   IP1710     out  8  conditioned input port 1710
//   IP4740     out  8  conditioned input port 4740
//   coin_busy  out  1  coin FSM in PULSE or HOLD
module cabinet_input_conditioner #(
    parameter int DB_PRESCALE    = 50000,
    parameter int DB_TICKS       = 3,
    parameter int COIN_PULSE_CYC = 5000000,
    parameter int COIN_HOLD_CYC  = 2500000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [7:0]  mod,
    input  logic [15:0] joystick,
    input  logic        test_sw,
    input  logic        vblank,
    output logic [7:0]  IP1710,
    output logic [7:0]  IP4740,
    output logic        coin_busy
);

    localparam int PW   = (DB_PRESCALE > 1) ? $clog2(DB_PRESCALE) : 1;
    localparam int CMAX = (COIN_PULSE_CYC > COIN_HOLD_CYC) ? COIN_PULSE_CYC : COIN_HOLD_CYC;
    localparam int TW   = $clog2(CMAX + 1);

    localparam logic [PW-1:0] PRE_LAST   = PW'(DB_PRESCALE - 1);
    localparam logic [2:0]    DB_LIMIT   = 3'(DB_TICKS);
    localparam logic [TW-1:0] PULSE_LOAD = TW'(COIN_PULSE_CYC - 1);
    localparam logic [TW-1:0] HOLD_LOAD  = TW'(COIN_HOLD_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_HOLD  = 2'd2
    } coin_state_t;

    logic [15:0]   jr;
    logic [15:0]   db;
    logic [2:0]    cnt [16];
    logic [PW-1:0] pre;
    logic          tick;
    logic          db7_prev;
    logic          coin_edge;
    coin_state_t   state;
    coin_state_t   state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic          coin;
    logic          t;
    logic [7:0]    map_1710;
    logic [7:0]    map_4740;
    logic          out_load;
    logic          unused_bits;

    assign tick = (pre == PRE_LAST);

    // Input register and debounce sample prescaler.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            jr  <= '0;
            pre <= '0;
        end else begin
            jr  <= joystick;
            pre <= tick ? '0 : pre + PW'(1);
        end
    end

    // Per-bit debounce: a bit flips only after DB_TICKS consecutive ticks of disagreement;
    // any agreeing tick restarts the count.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            db <= '0;
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < 16; i++) begin
                if (jr[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] + 3'd1 == DB_LIMIT) begin
                    db[i]  <= jr[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 3'd1;
                end
            end
        end
    end

    // Rising-edge detect on the debounced coin button.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            db7_prev <= 1'b0;
        end else begin
            db7_prev <= db[7];
        end
    end

    assign coin_edge = db[7] & ~db7_prev;

    // Coin FSM: state register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= S_IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    // Coin FSM: next state. Edges seen outside IDLE are dropped, so a held button
    // cannot retrigger once the holdoff ends.
    always_comb begin
        state_next = state;
        timer_next = timer;
        case (state)
            S_IDLE: begin
                if (coin_edge) begin
                    state_next = S_PULSE;
                    timer_next = PULSE_LOAD;
                end
            end
            S_PULSE: begin
                if (timer == '0) begin
                    state_next = S_HOLD;
                    timer_next = HOLD_LOAD;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            S_HOLD: begin
                if (timer == '0) begin
                    state_next = S_IDLE;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                timer_next = '0;
            end
        endcase
    end

    // Coin FSM: outputs.
    always_comb begin
        coin      = (state == S_PULSE);
        coin_busy = (state != S_IDLE);
    end

    assign t = ~test_sw;

    // Per-game port layout, bits 7..0.
    always_comb begin
        map_1710 = '0;
        map_4740 = '0;
        case (mod)
            8'd2: begin
                map_1710 = {t, db[9], 5'b00000, coin};
                map_4740 = {db[8], db[6], db[5], db[4], db[1], db[3], db[0], db[2]};
            end
            8'd4: begin
                map_1710 = {5'b00000, coin, db[8], t};
                map_4740 = {1'b0, db[9], 1'b0, db[11], 1'b0, db[10], db[4], 1'b0};
            end
            8'd5: begin
                map_1710 = {4'b0000, coin, 1'b0, db[4], t};
                map_4740 = {1'b0, db[6], db[5], db[4], db[2], db[1], db[3], db[0]};
            end
            default: begin
                map_1710 = {db[4], t, 2'b00, coin, 1'b0, db[6], db[5]};
                map_4740 = {4'b0000, db[2], db[3], db[1], db[0]};
            end
        endcase
    end

`ifdef INPUT_VBL_SYNC_EN
    logic [1:0] vbl_sync;
    logic       vbl_prev;
    logic       vbl_load;

    // vblank is asynchronous: two flops before any use, then a registered
    // rising-edge pulse that lets the output register reload one cycle later.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vbl_sync <= '0;
            vbl_prev <= 1'b0;
            vbl_load <= 1'b0;
        end else begin
            vbl_sync <= {vbl_sync[0], vblank};
            vbl_prev <= vbl_sync[1];
            vbl_load <= vbl_sync[1] & ~vbl_prev;
        end
    end

    assign out_load    = vbl_load;
    assign unused_bits = ^db[15:12];
`else
    assign out_load    = 1'b1;
    assign unused_bits = ^{db[15:12], vblank};
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            IP1710 <= '0;
            IP4740 <= '0;
        end else if (out_load) begin
            IP1710 <= map_1710;
            IP4740 <= map_4740;
        end
    end

endmodule

// File: tb/tb_cabinet_input_conditioner.sv
// tb/tb_cabinet_input_conditioner.sv - self-checking bench for cabinet_input_conditioner
module tb_cabinet_input_conditioner;

    localparam int PRE   = 4;
    localparam int TICKS = 3;
    localparam int PULSE = 20;
    localparam int HOLD  = 10;

    logic        clk_sys  = 1'b0;
    logic        reset    = 1'b1;
    logic [7:0]  mod      = 8'd0;
    logic [15:0] joystick = 16'h0000;
    logic        test_sw  = 1'b0;
    logic        vblank   = 1'b0;
    logic [7:0]  IP1710;
    logic [7:0]  IP4740;
    logic        coin_busy;

    int n_tests  = 0;
    int n_failed = 0;

    always #5 clk_sys = ~clk_sys;

    cabinet_input_conditioner #(
        .DB_PRESCALE   (PRE),
        .DB_TICKS      (TICKS),
        .COIN_PULSE_CYC(PULSE),
        .COIN_HOLD_CYC (HOLD)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .mod      (mod),
        .joystick (joystick),
        .test_sw  (test_sw),
        .vblank   (vblank),
        .IP1710   (IP1710),
        .IP4740   (IP4740),
        .coin_busy(coin_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference mapping written bit by bit from the port tables.
    function automatic logic [15:0] map_ref(input logic [7:0] g, input logic sw,
                                            input logic [15:0] j, input logic c);
        logic [7:0] a;
        logic [7:0] b;
        logic       tt;
        a  = '0;
        b  = '0;
        tt = ~sw;
        if (g == 8'd2) begin
            a[7] = tt; a[6] = j[9]; a[0] = c;
            b[7] = j[8]; b[6] = j[6]; b[5] = j[5]; b[4] = j[4];
            b[3] = j[1]; b[2] = j[3]; b[1] = j[0]; b[0] = j[2];
        end else if (g == 8'd4) begin
            a[2] = c; a[1] = j[8]; a[0] = tt;
            b[6] = j[9]; b[4] = j[11]; b[2] = j[10]; b[1] = j[4];
        end else if (g == 8'd5) begin
            a[3] = c; a[1] = j[4]; a[0] = tt;
            b[6] = j[6]; b[5] = j[5]; b[4] = j[4]; b[3] = j[2];
            b[2] = j[1]; b[1] = j[3]; b[0] = j[0];
        end else begin
            a[7] = j[4]; a[6] = tt; a[3] = c; a[1] = j[6]; a[0] = j[5];
            b[3] = j[2]; b[2] = j[3]; b[1] = j[1]; b[0] = j[0];
        end
        return {a, b};
    endfunction

    // Behavioural model: time is a cycle count since reset, a debounce sample happens
    // whenever that count is PRE-1 mod PRE, and an accepted coin is remembered only by
    // the cycle its pulse starts.
    int          m_now   = 0;
    int          m_start = -1000;
    logic [15:0] m_jr    = '0;
    logic [15:0] m_db    = '0;
    int          m_cnt [16];
    logic        m_prev7 = 1'b0;
    logic [7:0]  m_1710  = '0;
    logic [7:0]  m_4740  = '0;

    task automatic model_step();
        logic [15:0] pair;
        logic        coin_now;
        logic        busy_now;
        if (reset) begin
            m_now   = 0;
            m_start = -1000;
            m_jr    = '0;
            m_db    = '0;
            m_prev7 = 1'b0;
            m_1710  = '0;
            m_4740  = '0;
            for (int i = 0; i < 16; i++) m_cnt[i] = 0;
        end else begin
            coin_now = ((m_now - m_start) < PULSE);
            busy_now = ((m_now - m_start) < PULSE + HOLD);
            pair     = map_ref(mod, test_sw, m_db, coin_now);
            m_1710   = pair[15:8];
            m_4740   = pair[7:0];
            if (!busy_now && m_db[7] && !m_prev7) m_start = m_now + 1;
            m_prev7 = m_db[7];
            if ((m_now % PRE) == PRE - 1) begin
                for (int i = 0; i < 16; i++) begin
                    if (m_jr[i] == m_db[i]) begin
                        m_cnt[i] = 0;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                        if (m_cnt[i] == TICKS) begin
                            m_db[i]  = m_jr[i];
                            m_cnt[i] = 0;
                        end
                    end
                end
            end
            m_jr  = joystick;
            m_now = m_now + 1;
        end
    endtask

    always @(posedge clk_sys) model_step();

    // One clock; outputs compared against the model at the falling edge.
    task automatic cyc();
        @(negedge clk_sys);
        check_eq("ip1710", IP1710, m_1710);
        check_eq("ip4740", IP4740, m_4740);
        check_eq("coin_busy", coin_busy, ((m_now - m_start) < PULSE + HOLD) ? 1 : 0);
    endtask

    task automatic wait_busy(input string tag);
        int k;
        k = 0;
        while (coin_busy !== 1'b1 && k < 60) begin
            cyc();
            k++;
        end
        check_eq(tag, coin_busy, 1);
    endtask

    int lat;
    int pulse_len;
    int busy_len;
    int rises;
    logic prev3;

    initial begin
        for (int i = 0; i < 16; i++) m_cnt[i] = 0;

        // Reset with all buttons pressed.
        reset    = 1'b1;
        joystick = 16'hFFFF;
        @(posedge clk_sys);
        for (int k = 0; k < 5; k++) begin
            cyc();
            check_eq("rst_ip1710", IP1710, 0);
            check_eq("rst_ip4740", IP4740, 0);
            check_eq("rst_busy", coin_busy, 0);
        end
        joystick = 16'h0000;
        reset    = 1'b0;
        repeat (20) cyc();

        // Debounce latency on joystick[0].
        joystick = 16'h0001;
        lat = 0;
        while (IP4740 !== 8'h01 && lat < 40) begin
            cyc();
            lat++;
        end
        check_eq("db_reached", IP4740, 8'h01);
        check_eq("db_latency_window", (lat >= 2 * PRE + 3 && lat <= 3 * PRE + 2) ? 1 : 0, 1);

        // A glitch lasting one sample period on joystick[2] must not reach IP4740[3].
        joystick = 16'h0005;
        repeat (PRE) cyc();
        joystick = 16'h0001;
        for (int k = 0; k < 30; k++) begin
            cyc();
            check_eq("glitch_bit", IP4740[3], 0);
        end
        joystick = 16'h0000;
        repeat (30) cyc();

        // Coin held 200 cycles: one pulse of PULSE cycles, busy for PULSE+HOLD.
        joystick  = 16'h0080;
        pulse_len = 0;
        busy_len  = 0;
        rises     = 0;
        prev3     = IP1710[3];
        for (int k = 0; k < 200; k++) begin
            cyc();
            if (IP1710[3]) pulse_len++;
            if (coin_busy) busy_len++;
            if (IP1710[3] && !prev3) rises++;
            prev3 = IP1710[3];
        end
        check_eq("coin_pulse_len", pulse_len, PULSE);
        check_eq("coin_busy_len", busy_len, PULSE + HOLD);
        check_eq("coin_single_pulse", rises, 1);

        // Holdoff: release inside PULSE, re-press so the debounced edge lands in HOLD.
        joystick = 16'h0000;
        repeat (30) cyc();
        joystick = 16'h0080;
        wait_busy("holdoff_first_busy");
        joystick = 16'h0000;
        rises = 0;
        prev3 = IP1710[3];
        for (int k = 0; k < 94; k++) begin
            if (k == 14) joystick = 16'h0080;
            cyc();
            if (IP1710[3] && !prev3) rises++;
            prev3 = IP1710[3];
        end
        check_eq("holdoff_one_pulse", rises, 1);
        joystick = 16'h0000;
        repeat (30) cyc();
        check_eq("holdoff_idle", coin_busy, 0);
        joystick = 16'h0080;
        wait_busy("second_busy");
        pulse_len = 0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (IP1710[3]) pulse_len++;
        end
        check_eq("second_pulse_len", pulse_len, PULSE);
        joystick = 16'h0000;
        repeat (30) cyc();

        // Mapping: mplanets during a pulse, then switch to tylz.
        mod      = 8'd2;
        joystick = 16'h0180;
        wait_busy("map_busy");
        cyc();
        check_eq("mplanets_1710", IP1710, 8'h81);
        check_eq("mplanets_4740", IP4740, 8'h80);
        mod = 8'd5;
        cyc();
        check_eq("tylz_1710", IP1710, 8'h09);
        check_eq("tylz_4740", IP4740, 8'h00);
        joystick = 16'h0000;
        repeat (40) cyc();

        // Randomised traffic against the model, with one reset mid-run.
        for (int it = 0; it < 300; it++) begin
            int hold;
            if ($urandom_range(0, 3) == 0) mod = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) test_sw = ~test_sw;
            if ($urandom_range(0, 1) == 0) joystick = 16'($urandom);
            else joystick = joystick ^ 16'(1 << $urandom_range(0, 11));
            vblank = 1'($urandom);
            if (it == 150) begin
                reset = 1'b1;
                repeat (2) cyc();
                reset = 1'b0;
            end
            hold = $urandom_range(1, 24);
            repeat (hold) cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
